// File: rtl/alu64_pkg.sv
// Shared opcode constants and command/result payload types for the ALU issue stage.
package alu64_pkg;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_NOP = 4'h1;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  op;
   } alu_cmd_t;

   typedef struct packed {
      logic [63:0] result;
      logic [3:0]  op;
   } alu_res_t;
endpackage

// File: rtl/alu64_issue_if.sv
// Command-in and result-out handshakes of the ALU issue stage.
interface alu64_issue_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_a;
   logic [63:0] in_b;
   logic [3:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [3:0]  out_op;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_op
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_result, out_op
   );
endinterface

// File: rtl/alu64_fifo.sv
// Synchronous FIFO, power-of-two depth; head data reads as zero while empty.
module alu64_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full, do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is allowed only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign rdata = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/alu64_issue.sv
// Issue stage: command FIFO -> registered ALU -> result buffer, strictly in order.
module alu64_issue
   import alu64_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int RES_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   alu64_issue_if.slave           io,
   output logic [63:0]            alu_a,
   output logic [63:0]            alu_b,
   output logic [3:0]             alu_op,
   input  logic [63:0]            alu_result,
   output logic [$clog2(DEPTH):0] cmd_count
);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int RCW = $clog2(RES_DEPTH) + 1;
   localparam int OW  = RCW + 1;

   alu_cmd_t       cmd_in, cmd_head;
   alu_res_t       res_in, res_head;
   logic [RCW-1:0] res_count;
   logic [OW-1:0]  res_occ;
   logic           cmd_empty, res_empty, cmd_push, out_pop, issue;
   logic           inflight_q, inflight_d;
   logic [3:0]     inflight_op_q, inflight_op_d;

   assign io.in_ready = (cmd_count < CW'(DEPTH)) && rst_n;
   assign cmd_push    = io.in_valid && io.in_ready;
   assign out_pop     = io.out_valid && io.out_ready;
   assign cmd_in      = '{a: io.in_a, b: io.in_b, op: io.in_op};
   assign res_in      = '{result: alu_result, op: inflight_op_q};

   alu64_fifo #(.WIDTH($bits(alu_cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
      .clk(clk), .rst_n(rst_n),
      .push(cmd_push), .wdata(cmd_in),
      .pop(issue), .rdata(cmd_head),
      .count(cmd_count), .empty(cmd_empty)
   );

   always_comb begin
      // Results already buffered plus the one in the ALU must leave room for this one.
      res_occ       = OW'(res_count) + OW'(inflight_q) - OW'(out_pop);
      issue         = !cmd_empty && (res_occ < OW'(RES_DEPTH));
      alu_a         = '0;
      alu_b         = '0;
      alu_op        = OP_NOP;
      inflight_d    = issue;
      inflight_op_d = inflight_op_q;
      if (issue) begin
         alu_a         = cmd_head.a;
         alu_b         = cmd_head.b;
         alu_op        = cmd_head.op;
         inflight_op_d = cmd_head.op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q    <= 1'b0;
         inflight_op_q <= '0;
      end else begin
         inflight_q    <= inflight_d;
         inflight_op_q <= inflight_op_d;
      end
   end

   // The issue gate guarantees a free slot whenever an in-flight result lands.
   alu64_fifo #(.WIDTH($bits(alu_res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
      .clk(clk), .rst_n(rst_n),
      .push(inflight_q), .wdata(res_in),
      .pop(out_pop), .rdata(res_head),
      .count(res_count), .empty(res_empty)
   );

   assign io.out_valid  = !res_empty;
   assign io.out_result = res_head.result;
   assign io.out_op     = res_head.op;
endmodule

// File: tb/tb_alu64_issue.sv
// Directed + random bench for alu64_issue with a behavioural ALU and an in-order result queue.
module tb_alu64_issue;
   import alu64_pkg::*;

   localparam int DEPTH     = 4;
   localparam int RES_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic [$clog2(DEPTH):0] cmd_count;

   alu64_issue_if bus();

   alu64_issue #(.DEPTH(DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .io(bus),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   // Registered ALU without reset: add for OP_ADD, zero for the other opcodes used here.
   always_ff @(posedge clk) alu_result <= (alu_op == OP_ADD) ? alu_a + alu_b : 64'h0;

   alu_res_t    exp_q[$];
   int          tests = 0, fails = 0;
   int          cyc_n = 0, n_pop = 0, n_acc = 0, first_pop = -1, last_pop = -1;
   logic [63:0] last_res = '0;
   logic [3:0]  last_op = '0;
   logic [3:0]  ops [3] = '{4'h0, 4'h1, 4'h3};

   function automatic alu_res_t ref_of(logic [63:0] a, logic [63:0] b, logic [3:0] op);
      alu_res_t r;
      r.result = (op == OP_ADD) ? a + b : 64'h0;
      r.op     = op;
      return r;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with inputs settled: record the transfers the next edge performs.
   task automatic cyc();
      alu_res_t e;
      if (bus.in_valid && bus.in_ready) begin
         exp_q.push_back(ref_of(bus.in_a, bus.in_b, bus.in_op));
         n_acc++;
      end
      if (bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) chk("spurious_out", 64'(bus.out_valid), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("out_result", bus.out_result, e.result);
            chk("out_op", 64'(bus.out_op), 64'(e.op));
            last_res = bus.out_result;
            last_op  = bus.out_op;
            n_pop++;
            if (first_pop < 0) first_pop = cyc_n;
            last_pop = cyc_n;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic send(logic [63:0] a, logic [63:0] b, logic [3:0] op);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(string tag);
      int k = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && k < 50) begin
         cyc();
         k++;
      end
      chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_cmd_count", 64'(cmd_count), 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'h1);
      chk("rst_out_result", bus.out_result, 64'd0);
      chk("rst_out_op", 64'(bus.out_op), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

      // Single add and its latency
      bus.out_ready = 1'b1;
      send(64'h5, 64'h7, 4'h0);
      chk("add_cmd_count", 64'(cmd_count), 64'd1);
      chk("add_issue_a", alu_a, 64'h5);
      chk("add_issue_b", alu_b, 64'h7);
      chk("add_issue_op", 64'(alu_op), 64'h0);
      chk("add_valid_e0", 64'(bus.out_valid), 64'd0);
      cyc();
      chk("add_valid_e1", 64'(bus.out_valid), 64'd0);
      chk("add_idle_op", 64'(alu_op), 64'h1);
      cyc();
      chk("add_valid_e2", 64'(bus.out_valid), 64'd1);
      chk("add_result", bus.out_result, 64'hC);
      chk("add_op", 64'(bus.out_op), 64'h0);
      cyc();
      chk("add_valid_after", 64'(bus.out_valid), 64'd0);

      // Wrap and non-add opcode
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'h0);
      drain("wrap");
      chk("wrap_result", last_res, 64'd0);
      send(64'h1234, 64'h5678, 4'h3);
      drain("op3");
      chk("op3_result", last_res, 64'd0);
      chk("op3_op", 64'(last_op), 64'h3);

      // Streaming: 8 back-to-back adds, one result per cycle
      n_pop = 0; first_pop = -1;
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_a = 64'(i); bus.in_b = 64'(i); bus.in_op = OP_ADD;
         chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
         cyc();
      end
      bus.in_valid = 1'b0;
      drain("stream");
      chk("stream_count", 64'(n_pop), 64'd8);
      chk("stream_consecutive", 64'(last_pop - first_pop), 64'd7);
      chk("stream_last", last_res, 64'd14);

      // Backpressure: 7 presented, only 6 accepted
      bus.out_ready = 1'b0;
      n_acc = 0;
      for (int k = 0; k < 7; k++) begin
         bus.in_valid = 1'b1;
         bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom};
         bus.in_op = (k % 2 == 1) ? 4'h3 : OP_ADD;
         cyc();
      end
      chk("bp_accepted", 64'(n_acc), 64'd6);
      chk("bp_cmd_count", 64'(cmd_count), 64'd4);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      bus.in_valid = 1'b0;
      repeat (3) cyc();
      chk("bp_head_stable", bus.out_result, exp_q[0].result);
      bus.out_ready = 1'b1;
      n_pop = 0;
      drain("bp");
      chk("bp_delivered", 64'(n_pop), 64'd6);
      bus.in_valid = 1'b1;
      cyc();
      bus.in_valid = 1'b0;
      drain("bp_retry");
      chk("bp_retry_delivered", 64'(n_pop), 64'd7);

      // Random traffic checked against the ordered model
      repeat (300) begin
         bus.in_valid  = ($urandom_range(0, 1) == 1);
         bus.in_a      = {$urandom, $urandom};
         bus.in_b      = {$urandom, $urandom};
         bus.in_op     = ops[$urandom_range(0, 2)];
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      drain("rand");

      // Reset with 3 queued and 1 in flight
      bus.out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         bus.in_valid = 1'b1;
         bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom}; bus.in_op = OP_ADD;
         cyc();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
      chk("mid_cmd_count", 64'(cmd_count), 64'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_cmd_count", 64'(cmd_count), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("mid_rst_alu_op", 64'(alu_op), 64'h1);
      exp_q.delete();
      cyc();
      cyc();
      rst_n = 1'b1;
      repeat (3) cyc();
      chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);
      send(64'h2, 64'h3, 4'h0);
      drain("post_rst");
      chk("post_rst_add", last_res, 64'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
